imm_encoder: RTL and testbench

- Inverse of the decode-side immediate generator. Takes a 32-bit immediate value, an ImmSrc type code and a base instruction word, and inserts the immediate into the RISC-V instruction bit fields. Returns the assembled 32-bit instruction.
- Used by the program-loader / self-test path that builds instructions in hardware before they are written to instruction memory.
- Two-stage valid/ready pipeline with range checking and an error counter.

---
 rtl/imm_pkg.sv | 21 ++
 rtl/imm_pack.sv | 37 +++
 rtl/imm_encoder.sv | 65 ++++++
 tb/tb_imm_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: immediate type codes, instruction field positions and range check shared by encoder and decoder
package imm_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_U = 3'b010,
    IMM_B = 3'b101,
    IMM_J = 3'b110
  } imm_src_e;
  localparam int RD_LSB = 7;
  localparam int U_LSB = 12;
  localparam int I_LSB = 20;
  localparam int F7_LSB = 25;
  // returns 1 when imm cannot be represented by the given format or src is not a known format
  function automatic logic imm_fits(input logic [31:0] imm, input logic [2:0] src);
    return (src == IMM_I || src == IMM_S) ? imm[31:12] != {20{imm[11]}} :
           (src == IMM_B) ? (imm[31:13] != {19{imm[12]}}) || imm[0] :
           (src == IMM_U) ? imm[31:20] != {12{imm[19]}} :
           (src == IMM_J) ? (imm[31:21] != {11{imm[20]}}) || imm[0] : 1'b1;
  endfunction
endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational insertion of an immediate into the instruction fields of its format
// ports: base (instruction word), imm (sign-extended immediate), src (format code) -> instr
module imm_pack
  import imm_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [2:0]  src,
  output logic [31:0] instr
);
  logic unused_bits;
  assign unused_bits = ^imm[31:21];
  always_comb begin
    instr = base;
    case (imm_src_e'(src))
      IMM_I: instr[31:I_LSB] = imm[11:0];
      IMM_S: begin
        instr[31:F7_LSB] = imm[11:5];
        instr[RD_LSB+4:RD_LSB] = imm[4:0];
      end
      IMM_B: begin
        instr[31] = imm[12];
        instr[RD_LSB] = imm[11];
        instr[30:F7_LSB] = imm[10:5];
        instr[RD_LSB+4:RD_LSB+1] = imm[4:1];
      end
      IMM_U: instr[31:U_LSB] = imm[19:0];
      IMM_J: begin
        instr[31] = imm[20];
        instr[30:21] = imm[10:1];
        instr[20] = imm[11];
        instr[19:U_LSB] = imm[19:12];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline that inserts an immediate into an instruction word
// ports: in_valid/in_ready/base_in/imm_in/imm_src request side; out_valid/out_ready/instr_out/out_err
// response side; err_count saturating count of erroring output transfers, cleared by err_clr
module imm_encoder
  import imm_pkg::*;
#(
  parameter int ERR_CNT_W = 16,
  parameter logic [2:0] IMM_TYPE_DEFAULT = 3'b000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          base_in,
  input  logic [31:0]          imm_in,
  input  logic [2:0]           imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr_out,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);
  logic s1_valid, s1_err, s1_en, s2_en, xfer_err;
  logic [31:0] s1_base, s1_imm, packed_instr;
  logic [2:0] s1_src;
  assign s2_en = !out_valid || out_ready;
  assign s1_en = !s1_valid || s2_en;
  assign in_ready = s1_en;
  assign xfer_err = out_valid && out_ready && out_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err <= 1'b0;
      s1_base <= '0;
      s1_imm <= '0;
      s1_src <= IMM_TYPE_DEFAULT;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      s1_err <= imm_fits(imm_in, imm_src);
      s1_base <= base_in;
      s1_imm <= imm_in;
      s1_src <= imm_src;
    end
  imm_pack u_pack (
    .base (s1_base),
    .imm  (s1_imm),
    .src  (s1_src),
    .instr(packed_instr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      instr_out <= '0;
      out_err <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      instr_out <= packed_instr;
      out_err <= s1_err;
    end
  // a clear wins over the old value but still counts an error transferring in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else err_count <= err_clr ? ERR_CNT_W'(xfer_err) : err_count + ERR_CNT_W'(xfer_err && !(&err_count));
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed stimulus against a behavioural scoreboard model of imm_encoder
module tb_imm_encoder;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, err_clr = 0;
  logic in_ready, out_valid, out_err;
  logic [31:0] base_in = 0, imm_in = 0, instr_out;
  logic [2:0] imm_src = 0;
  logic [15:0] err_count;
  int n_cmp = 0, n_bad = 0, acc_n = 0, first_stall = -1;
  typedef struct {
    logic [31:0] instr;
    logic err;
    logic lit;
    logic [31:0] li;
    logic le;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic lit_on = 0, lit_e = 0, hold = 0, h_err = 0, x_err;
  logic [31:0] lit_i = 0, h_instr = 0;
  logic [15:0] cnt_m = 0;

  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .base_in(base_in),
    .imm_in(imm_in), .imm_src(imm_src), .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .out_err(out_err), .err_count(err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic model_err(input logic [31:0] imm, input logic [2:0] src);
    int s = $signed(imm);
    case (src)
      3'b000, 3'b001: return s < -2048 || s > 2047;
      3'b101: return s < -4096 || s > 4095 || imm[0];
      3'b010: return s < -524288 || s > 524287;
      3'b110: return s < -1048576 || s > 1048575 || imm[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_instr(input logic [31:0] b, input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'b000: return (b & 32'h000FFFFF) | (i << 20);
      3'b001: return (b & 32'h01FFF07F) | ((i & 32'hFE0) << 20) | ((i & 32'h1F) << 7);
      3'b101: return (b & 32'h01FFF07F) | ((i & 32'h1000) << 19) | ((i & 32'h800) >> 4)
                     | ((i & 32'h7E0) << 20) | ((i & 32'h1E) << 7);
      3'b010: return (b & 32'h00000FFF) | (i << 12);
      3'b110: return (b & 32'h00000FFF) | ((i & 32'h100000) << 11) | ((i & 32'h7FE) << 20)
                     | ((i & 32'h800) << 9) | (i & 32'hFF000);
      default: return b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cnt_m = 0;
      hold = 0;
    end else begin
      chk("err_count", {16'h0, err_count}, {16'h0, cnt_m});
      if (hold) begin
        chk("hold_valid", {31'h0, out_valid}, 1);
        chk("hold_instr", instr_out, h_instr);
        chk("hold_err", {31'h0, out_err}, {31'h0, h_err});
      end
      x_err = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stray_out", {31'h0, out_valid}, 0);
        else begin
          e = q.pop_front();
          x_err = e.err;
          chk("instr", instr_out, e.instr);
          chk("err", {31'h0, out_err}, {31'h0, e.err});
          if (e.lit) begin
            chk("lit_instr", instr_out, e.li);
            chk("lit_err", {31'h0, out_err}, {31'h0, e.le});
          end
        end
      end
      cnt_m = err_clr ? {15'h0, x_err} : (x_err && cnt_m != 16'hFFFF) ? cnt_m + 16'd1 : cnt_m;
      hold = out_valid && !out_ready;
      h_instr = instr_out;
      h_err = out_err;
      if (in_valid && in_ready)
        q.push_back('{model_instr(base_in, imm_in, imm_src), model_err(imm_in, imm_src), lit_on, lit_i, lit_e});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s);
    logic acc;
    base_in = b;
    imm_in = i;
    imm_src = s;
    in_valid = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_n++;
        in_valid = 0;
        lit_on = 0;
        return;
      end
      if (first_stall < 0) first_stall = acc_n;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: request not accepted within 200 cycles");
    in_valid = 0;
    lit_on = 0;
  endtask

  task automatic send_lit(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s,
                          input logic [31:0] li, input logic le);
    lit_on = 1;
    lit_i = li;
    lit_e = le;
    chk("model_pin_instr", model_instr(b, i, s), li);
    chk("model_pin_err", {31'h0, model_err(i, s)}, {31'h0, le});
    send(b, i, s);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) idle(1);
    idle(2);
  endtask

  initial begin
    idle(2);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_out_err", {31'h0, out_err}, 0);
    chk("rst_err_count", {16'h0, err_count}, 0);
    rst = 0;
    idle(1);
    chk("in_ready_after_rst", {31'h0, in_ready}, 1);
    send_lit(32'h00000013, 32'hFFFFFFFF, 3'b000, 32'hFFF00013, 0);
    send_lit(32'h00000063, 32'h00000FFE, 3'b101, 32'h7E000FE3, 0);
    send_lit(32'h00000063, 32'h00000FFF, 3'b101, 32'h7E000FE3, 1);
    send_lit(32'h0000006F, 32'hFFF00000, 3'b110, 32'h8000006F, 0);
    send_lit(32'h00000037, 32'h00080000, 3'b010, 32'h80000037, 1);
    send_lit(32'h12345678, 32'h00000000, 3'b111, 32'h12345678, 1);
    send_lit(32'h00000023, 32'hFFFFF800, 3'b001, 32'h80000023, 0);
    send_lit(32'h00000023, 32'h00000800, 3'b001, 32'h80000023, 1);
    drain();
    chk("err_count_directed", {16'h0, err_count}, 4);
    send(32'hDEADBEEF, 32'h000007FF, 3'b000);
    send(32'hDEADBEEF, 32'h00000800, 3'b000);
    send(32'hA5A5A5A5, 32'h000FFFFE, 3'b110);
    send(32'hA5A5A5A5, 32'h00100000, 3'b110);
    send(32'hA5A5A5A5, 32'h00000001, 3'b110);
    send(32'h5A5A5A5A, 32'hFFF80000, 3'b010);
    send(32'h5A5A5A5A, 32'h0007FFFF, 3'b010);
    send(32'hFFFFFFFF, 32'hFFFFF000, 3'b101);
    send(32'hFFFFFFFF, 32'h00001000, 3'b101);
    send(32'h0F0F0F0F, 32'h00000555, 3'b001);
    send(32'h0F0F0F0F, 32'h00000555, 3'b011);
    drain();
    out_ready = 0;
    acc_n = 0;
    first_stall = -1;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join_none
    send(32'h00000013, 32'h00000001, 3'b000);
    send(32'h00000013, 32'h00000002, 3'b000);
    send(32'h00000023, 32'h00000003, 3'b001);
    send(32'h00000063, 32'h00000004, 3'b101);
    send(32'h00000037, 32'h00000005, 3'b010);
    chk("bp_first_stall", first_stall, 2);
    drain();
    for (int k = 0; k < 65540; k++) send(32'h0, 32'h0, 3'b111);
    drain();
    chk("err_count_sat", {16'h0, err_count}, 32'h0000FFFF);
    send(32'h0, 32'h0, 3'b111);
    idle(1);
    chk("clr_coincide_valid", {31'h0, out_valid}, 1);
    err_clr = 1;
    idle(1);
    err_clr = 0;
    chk("clr_coincide", {16'h0, err_count}, 1);
    err_clr = 1;
    idle(1);
    err_clr = 0;
    chk("clr_alone", {16'h0, err_count}, 0);
    send(32'h0, 32'h0, 3'b111);
    drain();
    chk("err_before_rst", {16'h0, err_count}, 1);
    out_ready = 0;
    send(32'h00000013, 32'h00000010, 3'b000);
    send(32'h00000013, 32'h00000020, 3'b000);
    chk("full_valid", {31'h0, out_valid}, 1);
    rst = 1;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 0);
    chk("async_rst_count", {16'h0, err_count}, 0);
    idle(2);
    rst = 0;
    out_ready = 1;
    idle(5);
    chk("no_stale_out", {31'h0, out_valid}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
